// File: rtl/cla4_seq_ctrl.sv
// Wide adder sequencer: streams operand nibbles, LSB first, through one external
// 4-bit carry-look-ahead slice and returns {cout,sum} over a valid/ready port.
module cla4_seq_ctrl #(
   parameter int NIBBLES = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [4*NIBBLES-1:0] a,
   input  logic [4*NIBBLES-1:0] b,
   input  logic                 cin,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [4*NIBBLES-1:0] sum,
   output logic                 cout,
   output logic [3:0]           cla_a,
   output logic [3:0]           cla_b,
   output logic                 cla_cin,
   input  logic [3:0]           cla_y,
   input  logic                 cla_cout
);

   localparam int W  = 4 * NIBBLES;
   localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]    state;
   logic [IW-1:0] idx;
   logic          carry;
   logic [W-1:0]  a_reg;
   logic [W-1:0]  b_reg;

   // Handshakes: a transfer happens on a rising edge where valid && ready are both
   // high; a requester keeps valid and its data stable until that edge.
   assign in_ready  = (state == S_IDLE);
   assign out_valid = (state == S_DONE);

   // Slice inputs come only from registers, so the slice's combinational outputs
   // never loop back into these signals.
   always_comb begin
      cla_a   = 4'd0;
      cla_b   = 4'd0;
      cla_cin = 1'b0;
      if (state == S_RUN) begin
         cla_a   = a_reg[{idx, 2'b00} +: 4];
         cla_b   = b_reg[{idx, 2'b00} +: 4];
         cla_cin = carry;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         idx   <= '0;
         carry <= 1'b0;
         a_reg <= '0;
         b_reg <= '0;
         sum   <= '0;
         cout  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  a_reg <= a;
                  b_reg <= b;
                  carry <= cin;
                  idx   <= '0;
                  sum   <= '0;
                  state <= S_RUN;
               end
            end
            S_RUN: begin
               sum[{idx, 2'b00} +: 4] <= cla_y;
               carry                  <= cla_cout;
               if (idx == LAST) begin
                  cout  <= cla_cout;
                  idx   <= '0;
                  state <= S_DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            S_DONE: begin
               if (out_ready) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
